// File: rtl/sum_block_if.sv
// ============================================================================
// sum_block_if : propagate/carry inputs and sum outputs of the CLA sum stage
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sum_block_if;
  logic p1, p2, p3, p4;
  logic c0, c1, c2, c3;
  logic s1, s2, s3, s4;

  modport master (
    output p1, p2, p3, p4,
    output c0, c1, c2, c3,
    input  s1, s2, s3, s4
  );

  modport slave (
    input  p1, p2, p3, p4,
    input  c0, c1, c2, c3,
    output s1, s2, s3, s4
  );
endinterface

`default_nettype wire

// File: rtl/sum_block.sv
// ============================================================================
// sum_block : sum stage of the 4-bit CLA adder, s(i) = p(i) ^ c(i-1)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_block #(
  parameter bit OUT_REG = 1'b1
) (
  input  wire       clk,
  input  wire       rst_n,
  sum_block_if.slave bus
);

  logic [3:0] s_d;

  // Vector order is {bit1..bit4}; every sum bit is independent of the others.
  assign s_d = {bus.p1, bus.p2, bus.p3, bus.p4} ^ {bus.c0, bus.c1, bus.c2, bus.c3};

  generate
    if (OUT_REG) begin : g_out_reg
      logic [3:0] s_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q <= 4'b0000;
        end else begin
          s_q <= s_d;
        end
      end

      assign {bus.s1, bus.s2, bus.s3, bus.s4} = s_q;
    end else begin : g_out_comb
      logic w_unused_clk_rst;

      // Clock and reset have no role in the combinational variant.
      assign w_unused_clk_rst = clk & rst_n;
      assign {bus.s1, bus.s2, bus.s3, bus.s4} = s_d;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sum_block.sv
// ============================================================================
// tb_sum_block : checks registered and combinational sum_block variants
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_block;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sum_block_if if_reg ();
  sum_block_if if_comb ();

  sum_block #(.OUT_REG(1'b1)) u_dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_reg.slave)
  );

  sum_block #(.OUT_REG(1'b0)) u_dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_comb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the four sums are the propagate nibble XOR the carry nibble.
  function automatic logic [3:0] model(input logic [7:0] v);
    return v[7:4] ^ v[3:0];
  endfunction

  task automatic drive(input logic [7:0] v);
    {if_reg.p1, if_reg.p2, if_reg.p3, if_reg.p4,
     if_reg.c0, if_reg.c1, if_reg.c2, if_reg.c3} = v;
    {if_comb.p1, if_comb.p2, if_comb.p3, if_comb.p4,
     if_comb.c0, if_comb.c1, if_comb.c2, if_comb.c3} = v;
  endtask

  function automatic logic [3:0] reg_out();
    return {if_reg.s1, if_reg.s2, if_reg.s3, if_reg.s4};
  endfunction

  function automatic logic [3:0] comb_out();
    return {if_comb.s1, if_comb.s2, if_comb.s3, if_comb.s4};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  v;
    logic [7:0]  prev;
    total = 0;
    bad   = 0;

    // Reset state: registered outputs cleared, combinational outputs live.
    rst_n = 1'b0;
    drive(8'hA6);
    #1;
    check("reset_reg", reg_out(), 4'b0000);
    check("reset_comb_live", comb_out(), model(8'hA6));
    @(posedge clk); #1;
    check("reset_reg_hold", reg_out(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep: combinational immediately, registered one edge later.
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      drive(v);
      #1;
      check("sweep_comb", comb_out(), model(v));
      @(posedge clk); #1;
      check("sweep_reg", reg_out(), model(v));
    end

    // Directed vectors with hand-derived results.
    drive(8'b1111_0000); #1;
    check("dir_f0_comb", comb_out(), 4'b1111);
    @(posedge clk); #1;
    check("dir_f0_reg", reg_out(), 4'b1111);
    drive(8'hFF); #1;
    check("dir_ff_comb", comb_out(), 4'b0000);
    @(posedge clk); #1;
    check("dir_ff_reg", reg_out(), 4'b0000);
    drive(8'b1010_0110); #1;
    check("dir_a6_comb", comb_out(), 4'b1100);
    @(posedge clk); #1;
    check("dir_a6_reg", reg_out(), 4'b1100);

    // Latency: back-to-back vectors, each visible exactly one edge later.
    drive(8'h00);
    @(posedge clk); #1;
    check("lat_first", reg_out(), 4'b0000);
    drive(8'hF0);
    #3;
    check("lat_hold_before_edge", reg_out(), 4'b0000);
    @(posedge clk); #1;
    check("lat_second", reg_out(), 4'b1111);

    // Asynchronous reset between edges discards the in-flight vector.
    drive(8'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", reg_out(), 4'b0000);
    check("async_reset_comb", comb_out(), 4'b1111);
    @(posedge clk); #1;
    check("reset_low_hold", reg_out(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'hF0);
    #1;
    check("release_no_replay", reg_out(), 4'b0000);
    @(posedge clk); #1;
    check("release_first_load", reg_out(), 4'b1111);

    // Random back-to-back stream against the model.
    prev = 8'hF0;
    for (int n = 0; n < 64; n++) begin
      v = 8'($urandom);
      drive(v);
      #1;
      check("rand_comb", comb_out(), model(v));
      check("rand_reg_prev", reg_out(), model(prev));
      @(posedge clk); #1;
      check("rand_reg", reg_out(), model(v));
      prev = v;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
